// File: rtl/pe_stream_feeder.sv
// pe_stream_feeder: drives one PE's input side. Reads image pixels and
// filter taps from two synchronous-read buffers and streams them into the MAC.
// It also sequences the accumulator clear, the result-buffer capture and the
// result-memory write for each group of NUM_RES results.
//
// Handshake: there is no valid/ready pair. A job is accepted when start=1 is
// seen in IDLE. busy is high from the next cycle through the DONE cycle, and
// done pulses for exactly one cycle at the end. start is ignored while busy.
module pe_stream_feeder #(
  parameter int FILT_SIZE = 16,
  parameter int NUM_RES   = 4,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        num_groups,
  input  logic [ADDR_W-1:0] img_base,
  input  logic [ADDR_W-1:0] filt_base,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] img_rd_adr,
  input  logic [7:0]        img_rd_data,
  output logic [ADDR_W-1:0] filt_rd_adr,
  input  logic [7:0]        filt_rd_data,
  output logic [7:0]        img_pixel,
  output logic [7:0]        filter_value,
  output logic              acc_en,
  output logic              rst_acc,
  output logic              res_buffer_en,
  output logic [7:0]        res_index,
  output logic              rst_res_reg,
  output logic              wr_en,
  output logic [7:0]        wr_adr,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_ISSUE   = 3'd2,
    S_DRAIN   = 3'd3,
    S_CAPTURE = 3'd4,
    S_WRITE   = 3'd5,
    S_RSTRES  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [7:0] K_LAST = 8'(FILT_SIZE - 1);
  localparam logic [7:0] R_LAST = 8'(NUM_RES - 1);

  state_t            state_q, state_d;
  logic [7:0]        k_q, k_d;            // tap index within a result
  logic [7:0]        r_q, r_d;            // result index within a group
  logic [7:0]        g_q, g_d;            // group index
  logic [7:0]        ng_q, ng_d;          // latched num_groups
  // res_base tracks img_base + (g*NUM_RES + r)*stride incrementally:
  // every result (including a group boundary) advances it by one stride.
  logic [ADDR_W-1:0] res_base_q, res_base_d;
  logic [ADDR_W-1:0] filt_base_q, filt_base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] img_hold_q, filt_hold_q;
  logic              acc_en_q;
  logic [ADDR_W-1:0] issue_img_adr, issue_filt_adr;

  assign issue_img_adr  = res_base_q + ADDR_W'(k_q);
  assign issue_filt_adr = filt_base_q + ADDR_W'(k_q);

  // State and job-context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      r_q         <= '0;
      g_q         <= '0;
      ng_q        <= '0;
      res_base_q  <= '0;
      filt_base_q <= '0;
      stride_q    <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      r_q         <= r_d;
      g_q         <= g_d;
      ng_q        <= ng_d;
      res_base_q  <= res_base_d;
      filt_base_q <= filt_base_d;
      stride_q    <= stride_d;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    r_d         = r_q;
    g_d         = g_q;
    ng_d        = ng_q;
    res_base_d  = res_base_q;
    filt_base_d = filt_base_q;
    stride_d    = stride_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ng_d        = num_groups;
          res_base_d  = img_base;
          filt_base_d = filt_base;
          stride_d    = stride;
          g_d         = '0;
          r_d         = '0;
          k_d         = '0;
          state_d     = (num_groups == 8'd0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        k_d     = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + 8'd1;
        end
      end
      S_DRAIN: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        res_base_d = res_base_q + stride_q;
        if (r_q < R_LAST) begin
          r_d     = r_q + 8'd1;
          state_d = S_CLEAR;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_RSTRES;
      end
      S_RSTRES: begin
        r_d = '0;
        g_d = g_q + 8'd1;
        state_d = (g_q + 8'd1 == ng_q) ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // acc_en lags issue by one cycle to line up with the buffers' read latency;
  // the hold registers keep the last issued addresses outside ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_en_q    <= 1'b0;
      img_hold_q  <= '0;
      filt_hold_q <= '0;
    end else begin
      acc_en_q <= (state_q == S_ISSUE);
      if (state_q == S_ISSUE) begin
        img_hold_q  <= issue_img_adr;
        filt_hold_q <= issue_filt_adr;
      end
    end
  end

  assign img_rd_adr    = (state_q == S_ISSUE) ? issue_img_adr  : img_hold_q;
  assign filt_rd_adr   = (state_q == S_ISSUE) ? issue_filt_adr : filt_hold_q;
  assign img_pixel     = img_rd_data;
  assign filter_value  = filt_rd_data;
  assign acc_en        = acc_en_q;
  assign rst_acc       = (state_q == S_CLEAR);
  assign res_buffer_en = (state_q == S_CAPTURE);
  assign res_index     = (state_q == S_CAPTURE) ? r_q : 8'd0;
  assign rst_res_reg   = (state_q == S_RSTRES);
  assign wr_en         = (state_q == S_WRITE);
  assign wr_adr        = (state_q == S_WRITE) ? g_q : 8'd0;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Bench for pe_stream_feeder: sync-read buffer models and a small PE model,
// directed jobs pushed into an expected-value scoreboard, and a negedge
// monitor that pops and compares whenever the DUT presents an event.
module tb_pe_stream_feeder;
  localparam int FS = 4;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          start = 1'b0;
  logic [7:0]    num_groups = '0;
  logic [AW-1:0] img_base = '0, filt_base = '0, stride = '0;
  logic [AW-1:0] img_rd_adr, filt_rd_adr;
  logic [7:0]    img_rd_data, filt_rd_data;
  logic [7:0]    img_pixel, filter_value, res_index, wr_adr;
  logic          acc_en, rst_acc, res_buffer_en, rst_res_reg, wr_en, busy, done;
  logic [2:0]    dbg_state;

  pe_stream_feeder #(.FILT_SIZE(FS), .NUM_RES(NR), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_groups(num_groups),
    .img_base(img_base), .filt_base(filt_base), .stride(stride),
    .img_rd_adr(img_rd_adr), .img_rd_data(img_rd_data),
    .filt_rd_adr(filt_rd_adr), .filt_rd_data(filt_rd_data),
    .img_pixel(img_pixel), .filter_value(filter_value),
    .acc_en(acc_en), .rst_acc(rst_acc), .res_buffer_en(res_buffer_en),
    .res_index(res_index), .rst_res_reg(rst_res_reg), .wr_en(wr_en),
    .wr_adr(wr_adr), .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  // ---------------- buffer and PE models ----------------
  logic [7:0]  img_mem [256];
  logic [7:0]  filt_mem[256];
  logic [31:0] acc;
  logic [31:0] slot[4];

  always @(posedge clk) begin
    img_rd_data  <= img_mem[img_rd_adr];
    filt_rd_data <= filt_mem[filt_rd_adr];
  end

  always @(posedge clk) begin
    if (rst_acc) acc <= '0;
    else if (acc_en) acc <= acc + 32'(img_pixel) * 32'(filter_value);
    if (res_buffer_en) slot[res_index[1:0]] <= acc;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_res_q[$];
  logic [7:0]  exp_idx_q[$];
  logic [7:0]  exp_wr_q[$];
  logic [7:0]  exp_img_q[$];
  logic [7:0]  exp_filt_q[$];
  logic [31:0] exp_done_q[$];
  logic [7:0]  adr_log[$];
  int n_vec = 0;
  int n_bad = 0;
  int t0 = 0;
  int busy_cnt = 0;
  int acc_cnt = 0;
  int acc_total = 0;
  int exp_acc_total = 0;
  logic done_seen = 1'b0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event seen with no expectation queued (t=%0t)", name, $time);
  endtask

  // Monitor: samples on the falling edge, pops and compares on each event.
  initial begin
    int rel, strobes;
    forever begin
      @(negedge clk);
      if (!rst && mon_en) begin
        rel = cyc - t0 + 1;
        strobes = int'(acc_en) + int'(rst_acc) + int'(res_buffer_en) + int'(wr_en) + int'(rst_res_reg);
        check("strobe_exclusive", 32'(strobes <= 1), 32'd1);
        if (busy) busy_cnt++;
        if (rst_acc) acc_cnt = 0;
        if (acc_en) begin
          acc_cnt++;
          acc_total++;
        end
        if (dbg_state == ST_ISSUE) begin
          adr_log.push_back(img_rd_adr);
          if (exp_img_q.size() == 0) unexpected("issue_adr");
          else begin
            check("img_rd_adr", 32'(img_rd_adr), 32'(exp_img_q.pop_front()));
            check("filt_rd_adr", 32'(filt_rd_adr), 32'(exp_filt_q.pop_front()));
          end
        end
        if (res_buffer_en) begin
          if (exp_res_q.size() == 0) unexpected("capture");
          else begin
            check("capture_sum", acc, exp_res_q.pop_front());
            check("res_index", 32'(res_index), 32'(exp_idx_q.pop_front()));
            check("acc_en_per_result", 32'(acc_cnt), 32'(FS));
          end
        end
        if (wr_en) begin
          if (exp_wr_q.size() == 0) unexpected("wr_en");
          else check("wr_adr", 32'(wr_adr), 32'(exp_wr_q.pop_front()));
        end
        if (done) begin
          done_seen = 1'b1;
          if (exp_done_q.size() == 0) unexpected("done");
          else begin
            logic [31:0] dc;
            dc = exp_done_q.pop_front();
            check("done_cycle", 32'(rel), dc);
            check("busy_cycles", 32'(busy_cnt), dc);
            check("acc_en_total", 32'(acc_total), 32'(exp_acc_total));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_idle(input string name);
    check({name, "_adr"}, 32'({img_rd_adr, filt_rd_adr}), 32'd0);
    check({name, "_ctl"}, 32'({acc_en, rst_acc, res_buffer_en, res_index, rst_res_reg,
                               wr_en, wr_adr, busy, done}), 32'd0);
    check({name, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Queue expectations, pulse start, optionally re-pulse or abort, await done.
  task automatic run_job(input logic [7:0] ng, input logic [7:0] ib, input logic [7:0] fb,
                         input logic [7:0] st, input int repulse_at, input int abort_at);
    logic [31:0] sum;
    logic [7:0]  ia, fa;
    int c;
    for (int g = 0; g < int'(ng); g++) begin
      for (int r = 0; r < NR; r++) begin
        sum = 0;
        for (int k = 0; k < FS; k++) begin
          ia = ib + 8'((g * NR + r) * int'(st) + k);
          fa = fb + 8'(k);
          exp_img_q.push_back(ia);
          exp_filt_q.push_back(fa);
          sum = sum + 32'(img_mem[ia]) * 32'(filt_mem[fa]);
        end
        exp_res_q.push_back(sum);
        exp_idx_q.push_back(8'(r));
      end
      exp_wr_q.push_back(8'(g));
    end
    exp_done_q.push_back(32'(int'(ng) * (NR * (FS + 3) + 2) + 1));
    exp_acc_total = int'(ng) * NR * FS;
    done_seen = 1'b0;
    @(negedge clk);
    num_groups = ng; img_base = ib; filt_base = fb; stride = st;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc; busy_cnt = 0; acc_total = 0; acc_cnt = 0;
    start = 1'b0;
    for (int i = 0; i < 3000 && !done_seen; i++) begin
      @(posedge clk);
      #1;
      c = cyc - t0 + 1;
      start = (c == repulse_at);
      if (c == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle("abort");
        rst = 1'b0;
        exp_res_q.delete(); exp_idx_q.delete(); exp_wr_q.delete();
        exp_img_q.delete(); exp_filt_q.delete(); exp_done_q.delete();
        repeat (40) @(posedge clk);
        return;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(done_seen), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("leftover_results", 32'(exp_res_q.size() + exp_wr_q.size() + exp_img_q.size()), 32'd0);
    check("post_job_idle", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      img_mem[i]  = 8'(i);
      filt_mem[i] = 8'd1;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    // 1: single group, overlapping windows.
    run_job(8'd1, 8'd0, 8'd0, 8'd1, -1, -1);
    check("slot0", slot[0], 32'd6);
    check("slot1", slot[1], 32'd10);
    check("slot2", slot[2], 32'd14);
    check("slot3", slot[3], 32'd18);

    // 2: three groups, stride 4.
    adr_log.delete();
    run_job(8'd3, 8'd0, 8'd0, 8'd4, -1, -1);
    check("grp1_first_adr", 32'(adr_log[16]), 32'd16);

    // 3: image address wrap.
    adr_log.delete();
    run_job(8'd1, 8'd250, 8'd0, 8'd1, -1, -1);
    check("r2_k0", 32'(adr_log[8]),  32'd252);
    check("r2_k3", 32'(adr_log[11]), 32'd255);
    check("r3_k0", 32'(adr_log[12]), 32'd253);
    check("r3_k2", 32'(adr_log[14]), 32'd255);
    check("r3_k3_wrap", 32'(adr_log[15]), 32'd0);

    // 4: zero groups.
    run_job(8'd0, 8'd0, 8'd0, 8'd1, -1, -1);

    // 5: reset during ISSUE of result 2, then a fresh full job.
    run_job(8'd1, 8'd0, 8'd0, 8'd1, -1, 17);
    run_job(8'd1, 8'd0, 8'd0, 8'd1, -1, -1);
    check("fresh_slot2", slot[2], 32'd14);

    // 6: start re-pulsed while busy.
    run_job(8'd1, 8'd0, 8'd0, 8'd1, 10, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_stream_feeder.md
Name: pe_stream_feeder

Overview:
- Control/data driver on the input side of one PE. It reads image pixels and filter taps from two synchronous-read buffers and streams them into the PE's MAC.
- It sequences the PE's accumulator clear, result capture into the 4-slot result buffer, and result-memory write.
- One feeder per PE instance. A top-level controller starts it and waits for `done`.

Parameters:
- FILT_SIZE, 16: MAC taps per result (range 1..255).
- NUM_RES, 4: results per group; matches result-buffer slot count.
- ADDR_W, 8: buffer and result-memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin job; sampled only in IDLE.
- num_groups  in  8  groups to compute; sampled with start.
- img_base  in  ADDR_W  first image address; sampled with start.
- filt_base  in  ADDR_W  first filter address; sampled with start.
- stride  in  ADDR_W  image address step between consecutive results; sampled with start.
- img_rd_adr  out  ADDR_W  image buffer read address.
- img_rd_data  in  8  image buffer data, valid 1 cycle after address.
- filt_rd_adr  out  ADDR_W  filter buffer read address.
- filt_rd_data  in  8  filter buffer data, valid 1 cycle after address.
- img_pixel  out  8  to PE; combinational pass-through of img_rd_data.
- filter_value  out  8  to PE; combinational pass-through of filt_rd_data.
- acc_en  out  1  PE accumulate enable.
- rst_acc  out  1  PE accumulator clear.
- res_buffer_en  out  1  PE result-buffer write.
- res_index  out  8  PE result-buffer slot (0..NUM_RES-1, zero-extended).
- rst_res_reg  out  1  PE result-buffer clear.
- wr_en  out  1  PE result-memory write.
- wr_adr  out  8  PE result-memory address (= group index).
- busy  out  1  high from the cycle after start acceptance through the DONE cycle.
- done  out  1  one-cycle pulse at job end.

Behaviour:

Reset:
- rst forces state IDLE.
- All counters and registered outputs go to 0: acc_en, rst_acc, res_buffer_en, res_index, rst_res_reg, wr_en, wr_adr, busy, done, img_rd_adr, filt_rd_adr.
- rst mid-job aborts immediately. No further wr_en is issued.

States: IDLE, CLEAR, ISSUE, DRAIN, CAPTURE, WRITE, RSTRES, DONE.

- IDLE:
  - start=1 latches the job inputs and clears counters g (group) and r (result).
  - If num_groups=0, go to DONE; otherwise go to CLEAR.
  - start in any other state is ignored.
- CLEAR (1 cycle):
  - rst_acc=1.
  - Tap counter k=0.
  - Go to ISSUE.
- ISSUE (FILT_SIZE cycles, k=0..FILT_SIZE-1):
  - img_rd_adr = img_base + (g*NUM_RES + r)*stride + k.
  - filt_rd_adr = filt_base + k.
  - All address arithmetic is modulo 2^ADDR_W (wrap, no error).
  - acc_en is the 1-cycle-delayed issue valid. It is high from the 2nd ISSUE cycle through DRAIN, for exactly FILT_SIZE cycles.
  - After k=FILT_SIZE-1, go to DRAIN.
- DRAIN (1 cycle):
  - acc_en=1 for the last tap.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - res_buffer_en=1, res_index=r. The PE's mac_out now holds the complete sum.
  - If r<NUM_RES-1: r++, go to CLEAR.
  - Else go to WRITE.
- WRITE (1 cycle):
  - wr_en=1, wr_adr=g.
  - Go to RSTRES.
- RSTRES (1 cycle):
  - rst_res_reg=1, r=0, g++.
  - If g+1 == num_groups, go to DONE; otherwise go to CLEAR.
- DONE (1 cycle):
  - done=1.
  - Go to IDLE.

Timing and invariants:
- Cycles per result: FILT_SIZE+3. Cycles per group: NUM_RES*(FILT_SIZE+3)+2.
- With start sampled at edge 0, DONE occupies cycle num_groups*(NUM_RES*(FILT_SIZE+3)+2)+1.
- rst_acc, acc_en, res_buffer_en, wr_en and rst_res_reg are mutually exclusive in every cycle.
- Outside their states, all PE control strobes are 0. Addresses hold their last value.
- The feeder does no arithmetic on data. MAC width and saturation are owned by the PE.

Test Plan:
1. FILT_SIZE=4, NUM_RES=4, img[i]=i, filter all 1, img_base=0, stride=1, num_groups=1, start pulse:
   - captured slots are 6, 10, 14, 18;
   - one wr_en with wr_adr=0;
   - done exactly in cycle 31;
   - busy high in cycles 1..31.
2. Same configuration with num_groups=3, stride=4, img_base=0:
   - wr_adr sequence is 0, 1, 2;
   - group 1 first image address is 16;
   - done in cycle 91.
3. img_base=250, stride=1, FILT_SIZE=4:
   - img_rd_adr for result 2 is 252, 253, 254, 255;
   - result 3 wraps to 253, 254, 255, 0.
4. num_groups=0 with start:
   - done in cycle 1;
   - acc_en, res_buffer_en and wr_en stay 0 throughout.
5. rst asserted during the ISSUE state of result 2:
   - next cycle all outputs are 0 and state is IDLE;
   - no wr_en ever appears;
   - a fresh start runs the full job correctly.
6. start re-pulsed while busy, plus a monitor check throughout:
   - the second start is ignored and the cycle count is unchanged;
   - per-cycle check that at most one PE control strobe is high;
   - acc_en count per result equals FILT_SIZE.
